// File: rtl/complex_weight_mult_if.sv
// Sample/weight/output bundle for complex_weight_mult.
// master drives samples and weight loads; slave is the multiplier.
interface complex_weight_mult_if #(
    parameter int DW = 18,
    parameter int WW = 18
);
    logic signed [DW-1:0] dinI, dinQ;
    logic                 din_valid;
    logic signed [WW-1:0] wI, wQ;
    logic                 w_load, w_commit;
    logic signed [DW-1:0] doutI, doutQ;
    logic                 dout_valid, w_pending, ovf;

    modport master (
        output dinI, dinQ, din_valid, wI, wQ, w_load, w_commit,
        input  doutI, doutQ, dout_valid, w_pending, ovf
    );
    modport slave (
        input  dinI, dinQ, din_valid, wI, wQ, w_load, w_commit,
        output doutI, doutQ, dout_valid, w_pending, ovf
    );
endinterface

// File: rtl/complex_weight_mult.sv
// 3-stage complex multiply by a double-buffered Q1.16 weight, round-half-up.
// Define CWM_SATURATE_EN to clamp out-of-range results and drive ovf; otherwise results wrap.
module complex_weight_mult #(
    parameter int DW = 18,
    parameter int WW = 18
) (
    input  logic                     clk,
    input  logic                     rst,
    complex_weight_mult_if.slave     bus
);
    localparam int STAGES = 3;
    localparam int FRAC   = 16;
    localparam int PW     = DW + WW;
    localparam int SW     = PW + 1;

    typedef struct packed {
        logic [DW-1:0] i;
        logic [DW-1:0] q;
    } sample_t;

    typedef struct packed {
        logic [WW-1:0] i;
        logic [WW-1:0] q;
    } weight_t;

    typedef enum logic {IDLE, PEND} wstate_t;

    localparam weight_t              UNITY_W = '{i: WW'(1) << FRAC, q: '0};
    localparam logic signed [SW-1:0] HALF    = SW'(1) << (FRAC - 1);

    wstate_t wstate;
    weight_t shadow, active;

    // A commit in PEND moves the old shadow to active even when a load lands in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            wstate <= IDLE;
            shadow <= UNITY_W;
            active <= UNITY_W;
        end else begin
            case (wstate)
                IDLE: if (bus.w_load) begin
                    shadow <= '{i: bus.wI, q: bus.wQ};
                    wstate <= PEND;
                end
                PEND: begin
                    if (bus.w_commit) active <= shadow;
                    if (bus.w_load)        shadow <= '{i: bus.wI, q: bus.wQ};
                    else if (bus.w_commit) wstate <= IDLE;
                end
            endcase
        end
    end

    assign bus.w_pending = (wstate == PEND);

    logic [STAGES-1:0]    vld_pipe;
    sample_t              s1_d;
    weight_t              s1_w;
    logic signed [PW-1:0] p_ii, p_qq, p_iq, p_qi;

    always_ff @(posedge clk) begin
        if (rst) vld_pipe <= '0;
        else     vld_pipe <= {vld_pipe[STAGES-2:0], bus.din_valid};
    end

    // Each sample travels with the weight it saw in S1.
    always_ff @(posedge clk) begin
        s1_d <= '{i: bus.dinI, q: bus.dinQ};
        s1_w <= active;
        p_ii <= PW'($signed(s1_d.i)) * PW'($signed(s1_w.i));
        p_qq <= PW'($signed(s1_d.q)) * PW'($signed(s1_w.q));
        p_iq <= PW'($signed(s1_d.i)) * PW'($signed(s1_w.q));
        p_qi <= PW'($signed(s1_d.q)) * PW'($signed(s1_w.i));
    end

    logic signed [SW-1:0] sum_i, sum_q;
    logic signed [DW-1:0] res_i, res_q;

    always_comb begin
        sum_i = SW'(p_ii) - SW'(p_qq);
        sum_q = SW'(p_iq) + SW'(p_qi);
    end

`ifdef CWM_SATURATE_EN
    localparam logic signed [DW-1:0] SMAX = {1'b0, {(DW-1){1'b1}}};
    localparam logic signed [DW-1:0] SMIN = {1'b1, {(DW-1){1'b0}}};

    logic signed [SW-1:0] rnd_i, rnd_q;
    logic                 fit_i, fit_q;
    logic                 ovf_r;

    // A result fits when every bit from the DW sign bit upward agrees.
    always_comb begin
        rnd_i = (sum_i + HALF) >>> FRAC;
        rnd_q = (sum_q + HALF) >>> FRAC;
        fit_i = (&rnd_i[SW-1:DW-1]) | ~(|rnd_i[SW-1:DW-1]);
        fit_q = (&rnd_q[SW-1:DW-1]) | ~(|rnd_q[SW-1:DW-1]);
        res_i = fit_i ? rnd_i[DW-1:0] : (rnd_i[SW-1] ? SMIN : SMAX);
        res_q = fit_q ? rnd_q[DW-1:0] : (rnd_q[SW-1] ? SMIN : SMAX);
    end

    always_ff @(posedge clk) begin
        if (rst) ovf_r <= 1'b0;
        else     ovf_r <= vld_pipe[STAGES-2] & ~(fit_i & fit_q);
    end

    assign bus.ovf = ovf_r;
`else
    always_comb begin
        res_i = DW'((sum_i + HALF) >>> FRAC);
        res_q = DW'((sum_q + HALF) >>> FRAC);
    end

    assign bus.ovf = 1'b0;
`endif

    logic signed [DW-1:0] dout_i, dout_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            dout_i <= '0;
            dout_q <= '0;
        end else if (vld_pipe[STAGES-2]) begin
            dout_i <= res_i;
            dout_q <= res_q;
        end
    end

    assign bus.doutI      = dout_i;
    assign bus.doutQ      = dout_q;
    assign bus.dout_valid = vld_pipe[STAGES-1];
endmodule

// File: tb/tb_complex_weight_mult.sv
// Directed and randomized checks of complex_weight_mult against an arithmetic reference model.
module tb_complex_weight_mult;
    localparam int    DW    = 18;
    localparam int    WW    = 18;
    localparam int    UNITY = 65536;
    localparam longint MAXV = (64'sd1 <<< (DW - 1)) - 1;
    localparam longint MINV = -(64'sd1 <<< (DW - 1));

    logic clk = 1'b0;
    logic rst = 1'b1;

    complex_weight_mult_if #(.DW(DW), .WW(WW)) bus ();
    complex_weight_mult #(.DW(DW), .WW(WW)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    typedef struct {
        int due;
        int i;
        int q;
        bit ov;
    } exp_t;

    exp_t sb[$];

    int m_aI = UNITY, m_aQ = 0, m_sI = UNITY, m_sQ = 0;
    bit m_pend = 0;
    int m_oI = 0, m_oQ = 0;
    bit m_vld = 0, m_ov = 0;

    int dI = 0, dQ = 0, wIv = 0, wQv = 0;
    bit dv = 0, ld = 0, cm = 0;

    task automatic check(input string tag, input int got, input int exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    function automatic void narrow(input longint s, output int o, output bit ov);
        longint r;
        longint w;
        r  = (s + 64'sd32768) >>> 16;
        ov = 1'b0;
`ifdef CWM_SATURATE_EN
        if (r > MAXV)      begin o = int'(MAXV); ov = 1'b1; end
        else if (r < MINV) begin o = int'(MINV); ov = 1'b1; end
        else               o = int'(r);
        w = 0;
`else
        w = r & ((64'sd1 <<< DW) - 1);
        if (w > MAXV) w = w - (64'sd1 <<< DW);
        o = int'(w);
`endif
    endfunction

    task automatic set_in(input int i, input int q, input bit v,
                          input bit l = 0, input int wi = 0, input int wq = 0, input bit c = 0);
        dI = i; dQ = q; dv = v; ld = l; wIv = wi; wQv = wq; cm = c;
        bus.dinI = DW'(i); bus.dinQ = DW'(q); bus.din_valid = v;
        bus.wI = WW'(wi); bus.wQ = WW'(wq); bus.w_load = l; bus.w_commit = c;
    endtask

    // One clock: advance the reference model with the inputs seen at the edge, then compare.
    task automatic tick();
        exp_t e;
        bit   oi, oq;
        @(posedge clk);
        cyc++;
        if (rst) begin
            sb.delete();
            m_oI = 0; m_oQ = 0; m_vld = 0; m_ov = 0;
            m_aI = UNITY; m_aQ = 0; m_sI = UNITY; m_sQ = 0; m_pend = 0;
        end else begin
            m_vld = 0; m_ov = 0;
            if (sb.size() > 0 && sb[0].due == cyc) begin
                e = sb.pop_front();
                m_vld = 1; m_oI = e.i; m_oQ = e.q; m_ov = e.ov;
            end
            if (dv) begin
                narrow(longint'(dI) * m_aI - longint'(dQ) * m_aQ, e.i, oi);
                narrow(longint'(dI) * m_aQ + longint'(dQ) * m_aI, e.q, oq);
                e.ov  = oi | oq;
                e.due = cyc + 2;
                sb.push_back(e);
            end
            if (m_pend) begin
                if (cm) begin m_aI = m_sI; m_aQ = m_sQ; end
                if (ld) begin m_sI = wIv; m_sQ = wQv; end
                else if (cm) m_pend = 0;
            end else if (ld) begin
                m_sI = wIv; m_sQ = wQv; m_pend = 1;
            end
        end
        #1;
        check("dout_valid", int'(bus.dout_valid), int'(m_vld));
        check("doutI", int'(bus.doutI), m_oI);
        check("doutQ", int'(bus.doutQ), m_oQ);
        check("ovf", int'(bus.ovf), int'(m_ov));
        check("w_pending", int'(bus.w_pending), int'(m_pend));
    endtask

    task automatic idle(input int n);
        set_in(0, 0, 0);
        for (int k = 0; k < n; k++) tick();
    endtask

    initial begin
        set_in(0, 0, 0);
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        check("rst_doutI", int'(bus.doutI), 0);
        check("rst_dout_valid", int'(bus.dout_valid), 0);
        check("rst_w_pending", int'(bus.w_pending), 0);

        // unity passthrough
        set_in(1000, -2000, 1); tick();
        idle(2);
        check("pass_valid", int'(bus.dout_valid), 1);
        check("pass_I", int'(bus.doutI), 1000);
        check("pass_Q", int'(bus.doutQ), -2000);

        // weight j; sample on the commit edge still sees unity
        set_in(0, 0, 0, 1, 0, 65536); tick();
        set_in(1000, 500, 1, 0, 0, 0, 1); tick();
        set_in(1000, 500, 1); tick();
        idle(1);
        check("j_old_I", int'(bus.doutI), 1000);
        check("j_old_Q", int'(bus.doutQ), 500);
        idle(1);
        check("j_new_I", int'(bus.doutI), -500);
        check("j_new_Q", int'(bus.doutQ), 1000);
        idle(1);
        check("hold_valid", int'(bus.dout_valid), 0);
        check("hold_I", int'(bus.doutI), -500);

        // rounding
        set_in(0, 0, 0, 1, 32768, 0); tick();
        set_in(0, 0, 0, 0, 0, 0, 1); tick();
        set_in(3, -3, 1); tick();
        idle(2);
        check("rnd_I", int'(bus.doutI), 2);
        check("rnd_Q", int'(bus.doutQ), -1);

        // overflow
        set_in(0, 0, 0, 1, 65536, 65536); tick();
        set_in(0, 0, 0, 0, 0, 0, 1); tick();
        set_in(131071, 131071, 1); tick();
        idle(2);
        check("ovf_I", int'(bus.doutI), 0);
`ifdef CWM_SATURATE_EN
        check("ovf_Q", int'(bus.doutQ), 131071);
        check("ovf_flag", int'(bus.ovf), 1);
`else
        check("ovf_Q", int'(bus.doutQ), -2);
        check("ovf_flag", int'(bus.ovf), 0);
`endif
        idle(1);
        check("ovf_pulse_end", int'(bus.ovf), 0);

        // FSM: load A, load B + commit, commit, commit in IDLE
        set_in(0, 0, 0, 1, 0, 65536); tick();
        set_in(0, 0, 0, 1, 32768, 0, 1); tick();
        check("fsm_pend_after_both", int'(bus.w_pending), 1);
        set_in(1000, 500, 1); tick();
        idle(2);
        check("fsm_A_I", int'(bus.doutI), -500);
        check("fsm_A_Q", int'(bus.doutQ), 1000);
        set_in(0, 0, 0, 0, 0, 0, 1); tick();
        check("fsm_idle_after_commit", int'(bus.w_pending), 0);
        set_in(0, 0, 0, 0, 0, 0, 1); tick();
        check("fsm_idle_commit_ignored", int'(bus.w_pending), 0);
        set_in(3, -3, 1); tick();
        idle(2);
        check("fsm_B_I", int'(bus.doutI), 2);
        check("fsm_B_Q", int'(bus.doutQ), -1);

        // randomized stream with loads, commits and occasional reset
        for (int n = 0; n < 400; n++) begin
            set_in(int'($urandom_range(0, 262143)) - 131072,
                   int'($urandom_range(0, 262143)) - 131072,
                   $urandom_range(0, 3) != 0,
                   $urandom_range(0, 9) == 0,
                   int'($urandom_range(0, 262143)) - 131072,
                   int'($urandom_range(0, 262143)) - 131072,
                   $urandom_range(0, 9) == 0);
            rst = ($urandom_range(0, 49) == 0);
            tick();
        end
        rst = 1'b0;
        idle(3);

        // reset mid-stream restores unity and drops in-flight samples
        set_in(0, 0, 0, 1, 0, 65536); tick();
        set_in(0, 0, 0, 0, 0, 0, 1); tick();
        for (int n = 0; n < 4; n++) begin
            set_in(100 + n, -50 - n, 1); tick();
        end
        rst = 1'b1;
        set_in(700, 800, 1, 1, 5, 5, 1); tick();
        rst = 1'b0;
        check("mrst_valid0", int'(bus.dout_valid), 0);
        check("mrst_I0", int'(bus.doutI), 0);
        check("mrst_pend", int'(bus.w_pending), 0);
        set_in(1234, -4321, 1); tick();
        check("mrst_valid1", int'(bus.dout_valid), 0);
        set_in(55, 66, 1); tick();
        check("mrst_valid2", int'(bus.dout_valid), 0);
        idle(1);
        check("mrst_valid3", int'(bus.dout_valid), 1);
        check("mrst_unity_I", int'(bus.doutI), 1234);
        check("mrst_unity_Q", int'(bus.doutQ), -4321);
        idle(3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
